// File: rtl/romulus_tkx_loader.sv
// -----------------------------------------------------------------------------
// romulus_tkx_loader
//
// Purpose:
//   Loads the 128-bit tweakey as a stream of BUSWIDTH-wide beats and keeps the
//   round key for a Romulus TBC core. The round function supplies the next
//   round key (tkx_next). The correction logic supplies the inverse-scheduled
//   key (tkx_rewind), which restores the round-0 key on rewind.
//
// Parameters:
//   BUSWIDTH  beat width, legal values 8, 32, 64 and 128
//   ROUNDS    round steps per TBC call, legal range 1..63
//
// Ports:
//   clk         single clock, rising edge
//   rst_n       asynchronous active-low reset
//   load_start  one-cycle pulse that starts a key load (highest priority)
//   sdi_data    key beat; the first beat ends up most significant
//   sdi_valid   key beat valid
//   sdi_ready   high only in LOAD; a beat transfers on sdi_valid && sdi_ready
//   step        advance one round (READY/RUN)
//   rewind      restore the round-0 key (READY/RUN/DONE), beats step
//   tkx_next    next-round key from the round function
//   tkx_rewind  corrected key from the correction logic
//   tkx         current round key, registered
//   round_cnt   rounds taken since the last load or rewind
//   loaded      state READY
//   done        state DONE (round_cnt == ROUNDS)
//
// Configuration:
//   ROMULUS_TKX_SHADOW_EN  when defined, a shadow register captures the
//                          completed key. Rewind then restores the key from
//                          the shadow register and ignores tkx_rewind.
//                          When undefined, rewind loads tkx_rewind.
// -----------------------------------------------------------------------------
module romulus_tkx_loader #(
  parameter int BUSWIDTH = 32,
  parameter int ROUNDS   = 40
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load_start,
  input  logic [BUSWIDTH-1:0] sdi_data,
  input  logic                sdi_valid,
  output logic                sdi_ready,
  input  logic                step,
  input  logic                rewind,
  input  logic [127:0]        tkx_next,
  input  logic [127:0]        tkx_rewind,
  output logic [127:0]        tkx,
  output logic [5:0]          round_cnt,
  output logic                loaded,
  output logic                done
);

  localparam int         BEATS     = 128 / BUSWIDTH;
  localparam logic [4:0] LAST_BEAT = 5'(BEATS - 1);
  localparam logic [5:0] ROUNDS_C  = 6'(ROUNDS);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_READY = 3'd2,
    ST_RUN   = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t       state_r;
  logic [4:0]   beat_cnt_r;
  logic [127:0] tkx_r;
  logic [5:0]   round_cnt_r;
  logic         sdi_ready_r;
  logic         loaded_r;
  logic         done_r;

  logic         xfer_s;
  logic [127:0] shifted_s;
  logic [127:0] rewind_key_s;
  logic [5:0]   round_inc_s;

  // sdi_ready_r mirrors state LOAD, so the handshake needs no state decode
  assign xfer_s      = sdi_valid && sdi_ready_r;
  assign round_inc_s = round_cnt_r + 6'd1;

  // A full-width beat replaces the key, because there is nothing left to shift
  generate
    if (BUSWIDTH == 128) begin : g_full_beat
      assign shifted_s = 128'(sdi_data);
    end else begin : g_shift_beat
      assign shifted_s = {tkx_r[127-BUSWIDTH:0], sdi_data};
    end
  endgenerate

`ifdef ROMULUS_TKX_SHADOW_EN
  logic [127:0] shadow_r;
  logic         unused_rewind_s;

  // tkx_rewind has no function when the shadow copy supplies the round-0 key
  assign unused_rewind_s = ^tkx_rewind;

  // Capture the completed key on the final transfer of a load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_r <= 128'd0;
    end else if (!load_start && (state_r == ST_LOAD) && xfer_s
                 && (beat_cnt_r == LAST_BEAT)) begin
      shadow_r <= shifted_s;
    end else begin
      shadow_r <= shadow_r;
    end
  end

  assign rewind_key_s = shadow_r;
`else
  assign rewind_key_s = tkx_rewind;
`endif

  // Main FSM: state, key, counters and registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      beat_cnt_r  <= 5'd0;
      tkx_r       <= 128'd0;
      round_cnt_r <= 6'd0;
      sdi_ready_r <= 1'b0;
      loaded_r    <= 1'b0;
      done_r      <= 1'b0;
    end else if (load_start) begin
      // Restart from any state. The key is kept until new beats shift in.
      state_r     <= ST_LOAD;
      beat_cnt_r  <= 5'd0;
      round_cnt_r <= 6'd0;
      sdi_ready_r <= 1'b1;
      loaded_r    <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          sdi_ready_r <= 1'b0;
          loaded_r    <= 1'b0;
          done_r      <= 1'b0;
        end
        ST_LOAD: begin
          if (xfer_s) begin
            tkx_r <= shifted_s;
            if (beat_cnt_r == LAST_BEAT) begin
              state_r     <= ST_READY;
              beat_cnt_r  <= 5'd0;
              sdi_ready_r <= 1'b0;
              loaded_r    <= 1'b1;
            end else begin
              beat_cnt_r  <= beat_cnt_r + 5'd1;
            end
          end else begin
            beat_cnt_r <= beat_cnt_r;
          end
        end
        ST_READY, ST_RUN: begin
          if (rewind) begin
            tkx_r       <= rewind_key_s;
            round_cnt_r <= 6'd0;
            state_r     <= ST_READY;
            loaded_r    <= 1'b1;
          end else if (step) begin
            tkx_r       <= tkx_next;
            round_cnt_r <= round_inc_s;
            loaded_r    <= 1'b0;
            // A single-round configuration goes straight from READY to DONE
            if (round_inc_s == ROUNDS_C) begin
              state_r <= ST_DONE;
              done_r  <= 1'b1;
            end else begin
              state_r <= ST_RUN;
            end
          end else begin
            tkx_r <= tkx_r;
          end
        end
        ST_DONE: begin
          // Further steps do not wrap round_cnt. Only rewind or load leaves DONE.
          if (rewind) begin
            tkx_r       <= rewind_key_s;
            round_cnt_r <= 6'd0;
            state_r     <= ST_READY;
            loaded_r    <= 1'b1;
            done_r      <= 1'b0;
          end else begin
            tkx_r <= tkx_r;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          beat_cnt_r  <= 5'd0;
          round_cnt_r <= 6'd0;
          sdi_ready_r <= 1'b0;
          loaded_r    <= 1'b0;
          done_r      <= 1'b0;
        end
      endcase
    end
  end

  assign sdi_ready = sdi_ready_r;
  assign tkx       = tkx_r;
  assign round_cnt = round_cnt_r;
  assign loaded    = loaded_r;
  assign done      = done_r;

endmodule

// File: doc/romulus_tkx_loader.md
ROMULUS_TKX_LOADER -- requirements
Module: romulus_tkx_loader

Interface
REQ-001 SHALL have parameter BUSWIDTH, 32, sdi beat width; legal values 8, 32, 64, 128.
REQ-002 SHALL have parameter ROUNDS, 40, number of round steps per TBC call; legal 1..63.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port load_start  input  1  one-cycle pulse that begins a key load.
REQ-006 SHALL have port sdi_data  input  BUSWIDTH  key beat.
REQ-007 SHALL have port sdi_valid  input  1  key beat valid.
REQ-008 SHALL have port sdi_ready  output  1  loader accepts a beat.
REQ-009 SHALL have port step  input  1  advance one round.
REQ-010 SHALL have port rewind  input  1  restore the round-0 key.
REQ-011 SHALL have port tkx_next  input  128  next-round key from the round function.
REQ-012 SHALL have port tkx_rewind  input  128  corrected (inverse-scheduled) key from correction logic.
REQ-013 SHALL have port tkx  output  128  current round key, registered.
REQ-014 SHALL have port round_cnt  output  6  rounds taken since last load/rewind.
REQ-015 SHALL have port loaded  output  1  key valid, state READY.
REQ-016 SHALL have port done  output  1  state DONE (round_cnt == ROUNDS).

Function
REQ-017 SHALL implement FSM states IDLE, LOAD, READY, RUN, DONE.
REQ-018 SHALL move from any state to LOAD on load_start, clearing the beat counter and round_cnt; load_start has priority over step and rewind in the same cycle.
REQ-019 SHALL assert sdi_ready only in LOAD; a beat transfers when sdi_valid && sdi_ready.
REQ-020 SHALL shift tkx on each transfer as tkx <= {tkx[127-BUSWIDTH:0], sdi_data} (for BUSWIDTH=128, tkx <= sdi_data); first beat ends up most significant.
REQ-021 SHALL move LOAD -> READY in the cycle after the 128/BUSWIDTH-th transfer; sdi_ready deasserts in that same cycle.
REQ-022 SHALL ignore step and rewind in IDLE and LOAD.
REQ-023 SHALL, in READY or RUN with step high, load tkx <= tkx_next and increment round_cnt; READY -> RUN on the first step.
REQ-024 SHALL move RUN -> DONE in the cycle round_cnt becomes ROUNDS; step in DONE is ignored (no wrap).
REQ-025 SHALL, on rewind in READY, RUN or DONE, load the round-0 key per REQ-030/031, clear round_cnt and go to READY; rewind has priority over step.
REQ-026 SHALL keep tkx and round_cnt unchanged when no transfer, step or rewind is accepted.
REQ-027 SHALL drive loaded = (state==READY) and done = (state==DONE), both registered-state decodes with no combinational path from inputs.

Reset
REQ-028 SHALL on rst_n low immediately set state IDLE, tkx 0, round_cnt 0, beat counter 0, sdi_ready 0, loaded 0, done 0.
REQ-029 SHALL abandon any partial load or run on reset; after rst_n rises only load_start leaves IDLE.

Configuration
REQ-030 SHALL, with ROMULUS_TKX_SHADOW_EN defined, include a 128-bit shadow register captured with the completed key on LOAD -> READY; rewind loads tkx from shadow and tkx_rewind is ignored.
REQ-031 SHALL, without ROMULUS_TKX_SHADOW_EN, contain no shadow register; rewind loads tkx <= tkx_rewind.

Verification
REQ-032 SHALL test BUSWIDTH=32 load of beats 0x00112233, 0x44556677, 0x8899AABB, 0xCCDDEEFF -> tkx=0x00112233445566778899AABBCCDDEEFF, loaded=1 one cycle after 4th beat, sdi_ready=0.
REQ-033 SHALL test ROUNDS=40 with step held high from READY, tkx_next=tkx+1 -> done after 40 steps, round_cnt=40, further steps leave tkx and round_cnt unchanged.
REQ-034 SHALL test rewind in DONE -> with macro tkx equals loaded key and tkx_rewind=0xFF..FF ignored; without macro tkx=0xFF..FF; round_cnt=0, loaded=1.
REQ-035 SHALL test load_start and step both high in RUN at round_cnt=7 -> state LOAD, round_cnt=0, tkx unchanged, sdi_ready=1.
REQ-036 SHALL test rst_n low after 2 of 4 beats -> all outputs 0 at once; subsequent sdi_valid beats without load_start are not accepted.
REQ-037 SHALL test sdi_valid gaps (valid low 3 cycles between beats, BUSWIDTH=8, 16 beats) -> tkx shifts only on transfers, final key correct.
